// File: rtl/dff_share_arbiter_pkg.sv
// Shared types, defaults and the round-robin pick helper for dff_share_arbiter.
package dff_share_pkg;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_MAX_HOLD = 4;
    // Upper bound on requesters; the pick helper works on a vector this wide.
    localparam int unsigned MAX_REQ      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_first_from(input logic [MAX_REQ-1:0] req,
                                               input int unsigned n,
                                               input int unsigned ptr);
        rr_pick_t    r;
        int unsigned k;
        r = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                k = (ptr + i) % n;
                if (!r.found && req[k]) begin
                    r.found = 1'b1;
                    r.idx   = 3'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester/consumer bus of the shared-word arbiter.
// master: requester side (drives req/wdata); slave: the arbiter.
interface dff_share_arbiter_if
    import dff_share_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       grant;
    logic [WIDTH-1:0]       q;
    logic                   busy;
    logic                   timeout;

    modport master (output req, wdata, input grant, q, busy, timeout);
    modport slave  (input req, wdata, output grant, q, busy, timeout);

endinterface

// File: rtl/dff_share_arbiter_dff_word.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
module dff_word #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q;

    // Reset clears the word; otherwise load when enabled, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ writers.
// Optional hold limit: define DFF_SHARE_TIMEOUT_EN to revoke a grant after
// MAX_HOLD cycles and pulse timeout; undefined, a grant lasts while req holds.
module dff_share_arbiter
    import dff_share_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input logic               clk,
    input logic               rst,
    dff_share_arbiter_if.slave bus
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state_q,   state_d;
    logic [N_REQ-1:0] grant_q,   grant_d;
    logic [IW-1:0]    gidx_q,    gidx_d;
    logic [IW-1:0]    ptr_q,     ptr_d;
    logic             timeout_q, timeout_d;

    logic [MAX_REQ-1:0] req_ext;
    rr_pick_t           pick;
    logic               req_granted;
    logic               load_en;
    logic               hold_expire;
    logic [IW-1:0]      ptr_after;
    logic [WIDTH-1:0]   wdata_sel;
    logic [WIDTH-1:0]   slice_masked [N_REQ];

    // Grant is one-hot, so the write mux is an AND-OR of masked slices.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mux
        assign slice_masked[gi] = grant_q[gi] ? bus.wdata[gi*WIDTH +: WIDTH] : '0;
    end

    // Combine masked slices and pick the next winner from the pointer.
    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            wdata_sel = wdata_sel | slice_masked[i];
        end
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = bus.req;
        pick                 = rr_first_from(req_ext, N_REQ, int'(ptr_q));
    end

    assign req_granted = |(grant_q & bus.req);
    assign load_en     = (state_q == GRANT) && req_granted;
    assign ptr_after   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

`ifdef DFF_SHARE_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;

    // The MAX_HOLD-th grant cycle still loads, then the grant is revoked.
    assign hold_expire = (int'(hold_q) + 1 >= int'(MAX_HOLD));

    // Hold counter: zero on grant issue, count GRANT cycles, saturate.
    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE && pick.found) begin
            hold_d = '0;
        end else if (state_q == GRANT && hold_q != HW'(MAX_HOLD)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_expire = 1'b0;
`endif

    // Arbiter FSM next state, grant, pointer and timeout pulse.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    state_d                   = GRANT;
                    grant_d                   = '0;
                    grant_d[pick.idx[IW-1:0]] = 1'b1;
                    gidx_d                    = pick.idx[IW-1:0];
                end
            end
            GRANT: begin
                if (!req_granted || hold_expire) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    ptr_d     = ptr_after;
                    timeout_d = req_granted & hold_expire;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    dff_word #(.WIDTH(WIDTH)) u_word (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_en),
        .d_i    (wdata_sel),
        .q_o    (bus.q)
    );

    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.timeout = timeout_q;

endmodule
